// File: rtl/pixel_stream_buffer.sv
// Two-slot ping-pong pixel buffer: whole-block parallel load on the input side,
// LANES pixels per ready/valid beat on the output side.
module pixel_stream_buffer #(
  parameter int unsigned NUM_PIXELS  = 16,
  parameter int unsigned PIXEL_WIDTH = 16,
  parameter int unsigned LANES       = 1,
  parameter int unsigned LOW_WATER   = LANES,
  parameter int unsigned COUNT_WIDTH = $clog2(2*NUM_PIXELS)+1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NUM_PIXELS*PIXEL_WIDTH-1:0]  value_in,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [LANES*PIXEL_WIDTH-1:0]       value_out,
  output logic [COUNT_WIDTH-1:0]             level,
  output logic                               almost_empty,
  output logic                               empty,
  output logic                               underrun
);

  localparam int unsigned BLK_W  = NUM_PIXELS * PIXEL_WIDTH;
  localparam int unsigned BEAT_W = LANES * PIXEL_WIDTH;
  localparam int unsigned RD_W   = $clog2(NUM_PIXELS) + 1;
  localparam int unsigned RDX_W  = RD_W + 1;

  logic [1:0][BLK_W-1:0]  slot_q;
  logic [1:0]             valid_q, valid_d;
  logic                   head_q, head_d;
  logic [RD_W-1:0]        rd_q, rd_d;
  logic                   primed_q, primed_d;
  logic                   underrun_q, underrun_d;
  logic [COUNT_WIDTH-1:0] level_q, level_d;
  logic                   empty_q, empty_d;
  logic                   almost_empty_q, almost_empty_d;
  logic                   wr_en, wr_sel;
  logic                   enq, deq, last_beat;

  assign in_ready     = ~(valid_q[0] & valid_q[1]);
  assign out_valid    = valid_q[head_q];
  assign level        = level_q;
  assign empty        = empty_q;
  assign almost_empty = almost_empty_q;
  assign underrun     = underrun_q;

  assign enq       = in_valid & in_ready;
  assign deq       = out_valid & out_ready;
  assign last_beat = (({1'b0, rd_q} + RDX_W'(LANES)) == RDX_W'(NUM_PIXELS));

  // Output lanes come straight from the active slot at the read offset.
  always_comb begin
    value_out = '0;
    if (out_valid) begin
      value_out = BEAT_W'(slot_q[head_q] >> (rd_q * PIXEL_WIDTH));
    end
  end

  // Next-state: dequeue first, then enqueue into the slot that was free before the edge.
  always_comb begin
    valid_d    = valid_q;
    head_d     = head_q;
    rd_d       = rd_q;
    wr_en      = 1'b0;
    wr_sel     = head_q;
    primed_d   = primed_q | enq;
    underrun_d = underrun_q | (out_ready & ~out_valid & primed_q);

    if (deq) begin
      if (last_beat) begin
        valid_d[head_q] = 1'b0;
        head_d          = ~head_q;
        rd_d            = '0;
      end else begin
        rd_d = rd_q + RD_W'(LANES);
      end
    end

    if (enq) begin
      wr_en           = 1'b1;
      wr_sel          = valid_q[head_q] ? ~head_q : head_q;
      valid_d[wr_sel] = 1'b1;
      if (!valid_q[head_q]) begin
        rd_d = '0;
      end
    end

    level_d = level_q + (enq ? COUNT_WIDTH'(NUM_PIXELS) : '0)
                      - (deq ? COUNT_WIDTH'(LANES) : '0);
    empty_d        = (level_d == '0);
    almost_empty_d = (level_d != '0) && (level_d <= COUNT_WIDTH'(LOW_WATER));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q         <= '0;
      valid_q        <= '0;
      head_q         <= 1'b0;
      rd_q           <= '0;
      primed_q       <= 1'b0;
      underrun_q     <= 1'b0;
      level_q        <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b0;
    end else begin
      if (wr_en) begin
        slot_q[wr_sel] <= value_in;
      end
      valid_q        <= valid_d;
      head_q         <= head_d;
      rd_q           <= rd_d;
      primed_q       <= primed_d;
      underrun_q     <= underrun_d;
      level_q        <= level_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
    end
  end

endmodule

// File: tb/tb_pixel_stream_buffer.sv
// Directed bench for pixel_stream_buffer: a LANES=1 instance driven from a vector
// table, and a LANES=2 instance plus reset-mid-stream driven by hand.
module tb_pixel_stream_buffer;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // LANES=1 instance
  logic        a_iv, a_ir, a_ov, a_or, a_ae, a_emp, a_un;
  logic [31:0] a_vin;
  logic [7:0]  a_vo;
  logic [3:0]  a_lvl;

  // LANES=2 instance
  logic        b_iv, b_ir, b_ov, b_or, b_ae, b_emp, b_un;
  logic [31:0] b_vin;
  logic [15:0] b_vo;
  logic [3:0]  b_lvl;

  pixel_stream_buffer #(.NUM_PIXELS(4), .PIXEL_WIDTH(8), .LANES(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_valid(a_iv), .in_ready(a_ir), .value_in(a_vin),
    .out_valid(a_ov), .out_ready(a_or), .value_out(a_vo), .level(a_lvl),
    .almost_empty(a_ae), .empty(a_emp), .underrun(a_un));

  pixel_stream_buffer #(.NUM_PIXELS(4), .PIXEL_WIDTH(8), .LANES(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(b_iv), .in_ready(b_ir), .value_in(b_vin),
    .out_valid(b_ov), .out_ready(b_or), .value_out(b_vo), .level(b_lvl),
    .almost_empty(b_ae), .empty(b_emp), .underrun(b_un));

  typedef struct {
    logic        iv;
    logic [31:0] vin;
    logic        ordy;
    logic        ir;
    logic        ov;
    logic [7:0]  vo;
    logic [3:0]  lvl;
    logic        emp;
    logic        ae;
    logic        un;
  } vec_t;

  localparam logic [31:0] BLK_A = 32'h4433_2211;
  localparam logic [31:0] BLK_B = 32'h8877_6655;
  localparam logic [31:0] BLK_C = 32'hCCBB_AA99;

  int checks = 0;
  int errors = 0;
  vec_t tbl [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic ir, input logic ov, input logic [7:0] vo,
                       input logic [3:0] lvl, input logic emp, input logic ae, input logic un);
    chk({tag, ".in_ready"},     32'(a_ir),  32'(ir));
    chk({tag, ".out_valid"},    32'(a_ov),  32'(ov));
    chk({tag, ".value_out"},    32'(a_vo),  32'(vo));
    chk({tag, ".level"},        32'(a_lvl), 32'(lvl));
    chk({tag, ".empty"},        32'(a_emp), 32'(emp));
    chk({tag, ".almost_empty"}, 32'(a_ae),  32'(ae));
    chk({tag, ".underrun"},     32'(a_un),  32'(un));
  endtask

  task automatic chk_b(input string tag, input logic ir, input logic ov, input logic [15:0] vo,
                       input logic [3:0] lvl, input logic emp, input logic ae, input logic un);
    chk({tag, ".in_ready"},     32'(b_ir),  32'(ir));
    chk({tag, ".out_valid"},    32'(b_ov),  32'(ov));
    chk({tag, ".value_out"},    32'(b_vo),  32'(vo));
    chk({tag, ".level"},        32'(b_lvl), 32'(lvl));
    chk({tag, ".empty"},        32'(b_emp), 32'(emp));
    chk({tag, ".almost_empty"}, 32'(b_ae),  32'(ae));
    chk({tag, ".underrun"},     32'(b_un),  32'(un));
  endtask

  task automatic step_a(input logic iv, input logic [31:0] vin, input logic ordy);
    a_iv = iv; a_vin = vin; a_or = ordy;
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic iv, input logic [31:0] vin, input logic ordy);
    b_iv = iv; b_vin = vin; b_or = ordy;
    @(posedge clk); #1;
  endtask

  initial begin
    // Expected state is what the outputs show just after the edge that applied the inputs.
    //          iv    vin    or    ir    ov    vo     lvl   emp   ae    un
    tbl[0]  = '{1'b1, BLK_A, 1'b0, 1'b1, 1'b1, 8'h11, 4'd4, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, '0,    1'b1, 1'b1, 1'b1, 8'h22, 4'd3, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, '0,    1'b1, 1'b1, 1'b1, 8'h33, 4'd2, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, '0,    1'b1, 1'b1, 1'b1, 8'h44, 4'd1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, '0,    1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, '0,    1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, '0,    1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, BLK_A, 1'b1, 1'b1, 1'b1, 8'h11, 4'd4, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, BLK_B, 1'b1, 1'b0, 1'b1, 8'h22, 4'd7, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, BLK_C, 1'b1, 1'b0, 1'b1, 8'h33, 4'd6, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, '0,    1'b1, 1'b0, 1'b1, 8'h44, 4'd5, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, '0,    1'b1, 1'b1, 1'b1, 8'h55, 4'd4, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, '0,    1'b1, 1'b1, 1'b1, 8'h66, 4'd3, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b0, '0,    1'b1, 1'b1, 1'b1, 8'h77, 4'd2, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{1'b0, '0,    1'b1, 1'b1, 1'b1, 8'h88, 4'd1, 1'b0, 1'b1, 1'b1};
    tbl[15] = '{1'b1, BLK_C, 1'b1, 1'b1, 1'b1, 8'h99, 4'd4, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{1'b0, '0,    1'b0, 1'b1, 1'b1, 8'h99, 4'd4, 1'b0, 1'b0, 1'b1};
    tbl[17] = '{1'b0, '0,    1'b0, 1'b1, 1'b1, 8'h99, 4'd4, 1'b0, 1'b0, 1'b1};
    tbl[18] = '{1'b0, '0,    1'b0, 1'b1, 1'b1, 8'h99, 4'd4, 1'b0, 1'b0, 1'b1};
    tbl[19] = '{1'b0, '0,    1'b1, 1'b1, 1'b1, 8'hAA, 4'd3, 1'b0, 1'b0, 1'b1};
    tbl[20] = '{1'b0, '0,    1'b1, 1'b1, 1'b1, 8'hBB, 4'd2, 1'b0, 1'b0, 1'b1};
    tbl[21] = '{1'b0, '0,    1'b1, 1'b1, 1'b1, 8'hCC, 4'd1, 1'b0, 1'b1, 1'b1};
    tbl[22] = '{1'b0, '0,    1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b1};

    reset_n = 1'b0;
    a_iv = 1'b0; a_vin = '0; a_or = 1'b0;
    b_iv = 1'b0; b_vin = '0; b_or = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_a("reset_a", 1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
    chk_b("reset_b", 1'b1, 1'b0, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single block drain, underrun, ping-pong, enqueue on last beat, backpressure.
    for (int i = 0; i < 23; i++) begin
      step_a(tbl[i].iv, tbl[i].vin, tbl[i].ordy);
      chk_a($sformatf("vec%0d", i), tbl[i].ir, tbl[i].ov, tbl[i].vo, tbl[i].lvl,
            tbl[i].emp, tbl[i].ae, tbl[i].un);
    end
    step_a(1'b0, '0, 1'b0);

    // Two lanes per beat.
    step_b(1'b1, BLK_A, 1'b0);
    chk_b("lanes2_load", 1'b1, 1'b1, 16'h2211, 4'd4, 1'b0, 1'b0, 1'b0);
    step_b(1'b0, '0, 1'b1);
    chk_b("lanes2_beat0", 1'b1, 1'b1, 16'h4433, 4'd2, 1'b0, 1'b1, 1'b0);
    step_b(1'b0, '0, 1'b1);
    chk_b("lanes2_beat1", 1'b1, 1'b0, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0);
    step_b(1'b0, '0, 1'b0);
    chk_b("lanes2_idle", 1'b1, 1'b0, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0);

    // Fill both slots, drain three pixels, then reset asynchronously mid-cycle.
    step_a(1'b1, BLK_A, 1'b0);
    step_a(1'b1, BLK_B, 1'b0);
    chk_a("full", 1'b0, 1'b1, 8'h11, 4'd8, 1'b0, 1'b0, 1'b1);
    step_a(1'b0, '0, 1'b1);
    step_a(1'b0, '0, 1'b1);
    step_a(1'b0, '0, 1'b1);
    chk_a("pre_reset", 1'b0, 1'b1, 8'h44, 4'd5, 1'b0, 1'b0, 1'b1);
    a_or = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk_a("async_reset", 1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_a("in_reset", 1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    step_a(1'b1, BLK_C, 1'b0);
    chk_a("post_reset_load", 1'b1, 1'b1, 8'h99, 4'd4, 1'b0, 1'b0, 1'b0);
    step_a(1'b0, '0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
